band_level_meter: RTL



---
 rtl/band_level_meter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/band_level_meter.sv
// band_level_meter
//   Tracks the peak magnitude of each of 8 audio bands over a fixed frame
//   window. At each frame end the peaks are snapshotted, quantised one band
//   per cycle to a 3-bit log level, and published as a packed 24-bit word
//   together with a one-cycle start pulse for the bar-graph display.
//
//   Reset is synchronous and active-high on the port named resetn
//   (resetn=1 resets on the clk edge).
//
//   Optional build macro: BAND_LEVEL_DECAY_EN
//     defined   : published level = max(new_level, prev_level-1), so bars
//                 fall by at most one step per frame.
//     undefined : published level = new_level.
//
//   Parameter legality: MAG_W in 8..24, FRAME_CYCLES >= 16,
//   2**CNT_W > FRAME_CYCLES.

module band_level_meter #(
  parameter int MAG_W        = 16,
  parameter int FRAME_CYCLES = 6250000,
  parameter int CNT_W        = 24
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sample_valid,
  input  logic [2:0]       band_idx,
  input  logic [MAG_W-1:0] band_mag,
  output logic [23:0]      amp_freq,
  output logic             start,
  output logic             busy
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    QUANT   = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam int NUM_BANDS = 8;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   frame_cnt;
  logic               tick;
  logic [MAG_W-1:0]   peak  [NUM_BANDS];
  logic [MAG_W-1:0]   snap  [NUM_BANDS];
  logic [2:0]         level [NUM_BANDS];
  logic [2:0]         qidx;
  logic [23:0]        publish_word;

  // Log quantiser: level tracks the position of the leading one, with the
  // top eight bit positions mapping onto levels 0..7 and anything below
  // bit MAG_W-7 collapsing to 0.
  function automatic logic [2:0] quantise(input logic [MAG_W-1:0] p);
    int   msb;
    logic found;
    msb   = 0;
    found = 1'b0;
    for (int i = 0; i < MAG_W; i++) begin
      if (p[i]) begin
        msb   = i;
        found = 1'b1;
      end
    end
    if (!found || msb < MAG_W - 7) begin
      return 3'd0;
    end
    if (msb - (MAG_W - 8) > 7) begin
      return 3'd7;
    end
    return 3'(msb - (MAG_W - 8));
  endfunction

`ifdef BAND_LEVEL_DECAY_EN
  logic [2:0] held_level [NUM_BANDS];

  // Peak-hold with fall-back: a bar may drop by at most one level per frame.
  function automatic logic [2:0] decayed(input logic [2:0] new_level,
                                         input logic [2:0] prev_level);
    logic [2:0] floor_level;
    floor_level = (prev_level == 3'd0) ? 3'd0 : prev_level - 3'd1;
    return (new_level > floor_level) ? new_level : floor_level;
  endfunction
`endif

  // Frame end marker: true during the last cycle of every frame window.
  assign tick = (frame_cnt == CNT_W'(FRAME_CYCLES - 1));

  // The display sees "busy" for the whole quantise/publish sequence.
  assign busy = (state == QUANT) || (state == PUBLISH);

  // Free-running frame counter, independent of sample activity.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement or block order.
    if (resetn) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Per-band peak tracking; a tick starts a fresh frame, and a sample
  // arriving in the tick cycle already belongs to that new frame.
  always_ff @(posedge clk) begin
    // NOTE: peak/snap/level are small flop banks rather than RAM, so they
    // can be cleared with a reset loop; an inferred RAM would have no reset.
    if (resetn) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        peak[k] <= '0;
      end
    end else if (tick) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        peak[k] <= '0;
      end
      if (sample_valid) begin
        peak[band_idx] <= band_mag;
      end
    end else if (sample_valid && (band_mag > peak[band_idx])) begin
      peak[band_idx] <= band_mag;
    end
  end

  // Snapshot of the finished frame, frozen while the quantiser walks it.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        snap[k] <= '0;
      end
    end else if (tick) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        snap[k] <= peak[k];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic: accumulate, quantise 8 bands, publish once.
  always_comb begin
    // NOTE: defaulting every output of a combinational block before the
    // case keeps each path assigned, so no latch can be inferred.
    state_next = state;
    case (state)
      ACCUM:   if (tick) state_next = QUANT;
      QUANT:   if (qidx == 3'd7) state_next = PUBLISH;
      PUBLISH: state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Quantiser band pointer: restarts on the tick that launches QUANT and
  // wraps back to 0 naturally after band 7.
  always_ff @(posedge clk) begin
    if (resetn) begin
      qidx <= '0;
    end else if ((state == ACCUM) && tick) begin
      qidx <= '0;
    end else if (state == QUANT) begin
      qidx <= qidx + 3'd1;
    end
  end

  // Level table, filled one band per QUANT cycle from the snapshot.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        level[k] <= '0;
      end
    end else if (state == QUANT) begin
      level[qidx] <= quantise(snap[qidx]);
    end
  end

  // Pack the levels into the display word; band 0 occupies the low bits.
  always_comb begin
    publish_word = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
`ifdef BAND_LEVEL_DECAY_EN
      publish_word[3*k +: 3] = decayed(level[k], held_level[k]);
`else
      publish_word[3*k +: 3] = level[k];
`endif
    end
  end

`ifdef BAND_LEVEL_DECAY_EN
  // Remember what was last shown so the next frame can decay from it.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        held_level[k] <= '0;
      end
    end else if (state == PUBLISH) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        held_level[k] <= publish_word[3*k +: 3];
      end
    end
  end
`endif

  // Output register: amp_freq and start change together on the publish edge.
  always_ff @(posedge clk) begin
    if (resetn) begin
      amp_freq <= '0;
      start    <= 1'b0;
    end else begin
      start <= 1'b0;
      if (state == PUBLISH) begin
        amp_freq <= publish_word;
        start    <= 1'b1;
      end
    end
  end

endmodule
